pipe_hazard_scoreboard: RTL and testbench



---
 rtl/pipe_hazard_scoreboard_pkg.sv | 10 +
 rtl/pipe_hazard_scoreboard_if.sv | 30 +++
 rtl/pipe_hazard_scoreboard_match.sv | 30 +++
 rtl/pipe_hazard_scoreboard.sv | 71 +++++++
 tb/tb_pipe_hazard_scoreboard.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_scoreboard_pkg.sv
// pipe_hazard_scoreboard_pkg: shared encodings and entry layout for the hazard scoreboard.
package pipe_hazard_scoreboard_pkg;
    localparam int ASIZE_DEF = 5;
    localparam int FWD_RF = 0;
    typedef struct packed {
        logic valid;
        logic wen;
        logic is_load;
    } ent_flags_t;
endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// pipe_hazard_scoreboard_if: decode-slot inputs and hazard/forwarding outputs of the scoreboard.
interface pipe_hazard_scoreboard_if import pipe_hazard_scoreboard_pkg::*; #(
    parameter int ASIZE = ASIZE_DEF,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    localparam int SW = $clog2(DEPTH + 1);
    logic             id_valid;
    logic             id_ren1;
    logic [ASIZE-1:0] id_raddr1;
    logic             id_ren2;
    logic [ASIZE-1:0] id_raddr2;
    logic             id_wen;
    logic [ASIZE-1:0] id_waddr;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic [SW-1:0]    fwd_sel1;
    logic [SW-1:0]    fwd_sel2;
    logic [DEPTH-1:0] busy_map;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output id_valid, id_ren1, id_raddr1, id_ren2, id_raddr2, id_wen, id_waddr, id_is_load, flush,
        input  stall, fwd_sel1, fwd_sel2, busy_map, stall_cnt
    );
    modport slave (
        input  id_valid, id_ren1, id_raddr1, id_ren2, id_raddr2, id_wen, id_waddr, id_is_load, flush,
        output stall, fwd_sel1, fwd_sel2, busy_map, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_scoreboard_match.sv
// hazard_match_cmp: youngest-entry match priority encoder for one source operand.
module hazard_match_cmp #(
    parameter int ASIZE = 5,
    parameter int DEPTH = 3,
    parameter int IW    = 2
) (
    input  logic                        ren,
    input  logic [ASIZE-1:0]            src,
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0]            wen,
    input  logic [DEPTH-1:0]            is_load,
    input  logic [DEPTH-1:0][ASIZE-1:0] waddr,
    output logic                        hit,
    output logic [IW-1:0]               idx,
    output logic                        hit_load
);
    // Scan oldest to youngest so the lowest matching index wins; r0 never matches.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        hit_load = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ren && src != '0 && valid[k] && wen[k] && waddr[k] == src) begin
                hit = 1'b1;
                idx = IW'(k);
                hit_load = is_load[k];
            end
        end
    end
endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: tracks in-flight register writes after decode, raising stall and
// forwarding selects for the decode-stage operands.
module pipe_hazard_scoreboard import pipe_hazard_scoreboard_pkg::*; #(
    parameter int ASIZE      = ASIZE_DEF,
    parameter int DEPTH      = 3,
    parameter int FWD_EN     = 1,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16
) (
    input logic clk,
    input logic rst,
    pipe_hazard_scoreboard_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);
    ent_flags_t [DEPTH-1:0]        ent_q, ent_d;
    logic [DEPTH-1:0][ASIZE-1:0]   waddr_q, waddr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [DEPTH-1:0]              vld, wen, ld;
    logic                          hit1, hit2, ld1, ld2, haz1, haz2, stall, take;
    logic [SW-1:0]                 idx1, idx2;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            vld[k] = ent_q[k].valid;
            wen[k] = ent_q[k].wen;
            ld[k] = ent_q[k].is_load;
        end
    end

    hazard_match_cmp #(.ASIZE(ASIZE), .DEPTH(DEPTH), .IW(SW)) u_match1 (
        .ren(bus.id_ren1), .src(bus.id_raddr1), .valid(vld), .wen(wen), .is_load(ld),
        .waddr(waddr_q), .hit(hit1), .idx(idx1), .hit_load(ld1)
    );
    hazard_match_cmp #(.ASIZE(ASIZE), .DEPTH(DEPTH), .IW(SW)) u_match2 (
        .ren(bus.id_ren2), .src(bus.id_raddr2), .valid(vld), .wen(wen), .is_load(ld),
        .waddr(waddr_q), .hit(hit2), .idx(idx2), .hit_load(ld2)
    );

    // Without forwarding every match stalls, including WB, since the regfile has no write-through.
    always_comb begin
        haz1 = FWD_EN != 0 ? hit1 && ld1 && idx1 < SW'(LOAD_STAGE) : hit1;
        haz2 = FWD_EN != 0 ? hit2 && ld2 && idx2 < SW'(LOAD_STAGE) : hit2;
        stall = bus.id_valid && !bus.flush && (haz1 || haz2);
        take = bus.id_valid && !stall && !bus.flush;
        ent_d[0] = take ? {1'b1, bus.id_wen, bus.id_is_load} : 3'b000;
        waddr_d[0] = take ? bus.id_waddr : '0;
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
            waddr_d[k] = waddr_q[k-1];
        end
        cnt_d = stall && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= '0;
            waddr_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            waddr_q <= waddr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall = stall;
    assign bus.fwd_sel1 = FWD_EN != 0 && hit1 ? idx1 + SW'(1) : SW'(FWD_RF);
    assign bus.fwd_sel2 = FWD_EN != 0 && hit2 ? idx2 + SW'(1) : SW'(FWD_RF);
    assign bus.busy_map = vld & wen;
    assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed stimulus on a forwarding build and a no-forwarding build,
// checked every cycle against an issue-history model plus hand-computed literals.
module tb_pipe_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int now = 0;
    int ca = 0;
    int cb = 0;

    typedef struct {
        int cyc;
        bit wen;
        int wa;
        bit ld;
    } rec_t;
    rec_t qa[$];
    rec_t qb[$];

    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.ASIZE(5), .DEPTH(3), .CNT_W(16)) ifa ();
    pipe_hazard_scoreboard_if #(.ASIZE(5), .DEPTH(3), .CNT_W(3))  ifb ();

    pipe_hazard_scoreboard #(.ASIZE(5), .DEPTH(3), .FWD_EN(1), .LOAD_STAGE(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    pipe_hazard_scoreboard #(.ASIZE(5), .DEPTH(3), .FWD_EN(0), .LOAD_STAGE(2), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic put(input bit v, input bit r1, input int a1, input bit r2, input int a2,
                       input bit w, input int wa, input bit l, input bit f);
        ifa.id_valid = v;   ifb.id_valid = v;
        ifa.id_ren1 = r1;   ifb.id_ren1 = r1;
        ifa.id_raddr1 = 5'(a1); ifb.id_raddr1 = 5'(a1);
        ifa.id_ren2 = r2;   ifb.id_ren2 = r2;
        ifa.id_raddr2 = 5'(a2); ifb.id_raddr2 = 5'(a2);
        ifa.id_wen = w;     ifb.id_wen = w;
        ifa.id_waddr = 5'(wa);  ifb.id_waddr = 5'(wa);
        ifa.id_is_load = l; ifb.id_is_load = l;
        ifa.flush = f;      ifb.flush = f;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) cyc();
    endtask

    // An instruction accepted in cycle c sits in entry (now - c - 1) during cycle now.
    function automatic void eval(input rec_t q[$], input bit fwd, output bit st,
                                 output int s1, output int s2, output int bm);
        int y1, y2;
        bit l1, l2, h1, h2;
        y1 = -1; y2 = -1; l1 = 0; l2 = 0; bm = 0;
        foreach (q[i]) begin
            int k;
            k = now - q[i].cyc - 1;
            if (k >= 0 && k < 3 && q[i].wen) begin
                bm |= 1 << k;
                if (ifa.id_ren1 && ifa.id_raddr1 != 0 && q[i].wa == int'(ifa.id_raddr1) && (y1 < 0 || k < y1)) begin
                    y1 = k; l1 = q[i].ld;
                end
                if (ifa.id_ren2 && ifa.id_raddr2 != 0 && q[i].wa == int'(ifa.id_raddr2) && (y2 < 0 || k < y2)) begin
                    y2 = k; l2 = q[i].ld;
                end
            end
        end
        h1 = fwd ? (y1 >= 0 && l1 && y1 < 2) : (y1 >= 0);
        h2 = fwd ? (y2 >= 0 && l2 && y2 < 2) : (y2 >= 0);
        st = ifa.id_valid && !ifa.flush && (h1 || h2);
        s1 = (fwd && y1 >= 0) ? y1 + 1 : 0;
        s2 = (fwd && y2 >= 0) ? y2 + 1 : 0;
    endfunction

    always @(negedge clk) begin
        bit sa, sb;
        int f1, f2, bm;
        if (rst) begin
            qa.delete(); qb.delete(); ca = 0; cb = 0;
        end else begin
            eval(qa, 1'b1, sa, f1, f2, bm);
            chk("model a.stall", 32'(ifa.stall), int'(sa));
            chk("model a.fwd_sel1", 32'(ifa.fwd_sel1), f1);
            chk("model a.fwd_sel2", 32'(ifa.fwd_sel2), f2);
            chk("model a.busy_map", 32'(ifa.busy_map), bm);
            chk("model a.stall_cnt", 32'(ifa.stall_cnt), ca);
            eval(qb, 1'b0, sb, f1, f2, bm);
            chk("model b.stall", 32'(ifb.stall), int'(sb));
            chk("model b.fwd_sel1", 32'(ifb.fwd_sel1), f1);
            chk("model b.fwd_sel2", 32'(ifb.fwd_sel2), f2);
            chk("model b.busy_map", 32'(ifb.busy_map), bm);
            chk("model b.stall_cnt", 32'(ifb.stall_cnt), cb);
            if (ifa.id_valid && !ifa.flush && !sa) qa.push_back('{now, ifa.id_wen, int'(ifa.id_waddr), ifa.id_is_load});
            if (ifa.id_valid && !ifa.flush && !sb) qb.push_back('{now, ifa.id_wen, int'(ifa.id_waddr), ifa.id_is_load});
            if (sa && ca < 65535) ca++;
            if (sb && cb < 7) cb++;
        end
        now++;
    end

    initial begin
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset a.stall", 32'(ifa.stall), 0);
        chk("reset a.fwd_sel1", 32'(ifa.fwd_sel1), 0);
        chk("reset a.fwd_sel2", 32'(ifa.fwd_sel2), 0);
        chk("reset a.busy_map", 32'(ifa.busy_map), 0);
        chk("reset a.stall_cnt", 32'(ifa.stall_cnt), 0);
        chk("reset b.stall_cnt", 32'(ifb.stall_cnt), 0);
        cyc();
        rst = 1'b0;
        idle(1);
        // ALU producer r3, consumer sub r4,r3,r1
        put(1, 0, 0, 0, 0, 1, 3, 0, 0); cyc();
        put(1, 1, 3, 1, 1, 1, 4, 0, 0);
        chk("alu a.fwd_sel1", 32'(ifa.fwd_sel1), 1);
        chk("alu a.fwd_sel2", 32'(ifa.fwd_sel2), 0);
        chk("alu a.stall", 32'(ifa.stall), 0);
        chk("alu a.stall_cnt", 32'(ifa.stall_cnt), 0);
        chk("alu b.stall", 32'(ifb.stall), 1);
        chk("alu b.fwd_sel1", 32'(ifb.fwd_sel1), 0);
        cyc(); idle(3);
        // load-use: lw r5, add r6,r5,r2 held in decode
        put(1, 0, 0, 0, 0, 1, 5, 1, 0); cyc();
        put(1, 1, 5, 1, 2, 1, 6, 0, 0);
        chk("ldu c1 a.stall", 32'(ifa.stall), 1);
        cyc(); #1;
        chk("ldu c2 a.stall", 32'(ifa.stall), 1);
        cyc(); #1;
        chk("ldu c3 a.stall", 32'(ifa.stall), 0);
        chk("ldu c3 a.fwd_sel1", 32'(ifa.fwd_sel1), 3);
        chk("ldu c3 a.stall_cnt", 32'(ifa.stall_cnt), 2);
        chk("ldu c3 b.stall", 32'(ifb.stall), 1);
        cyc(); idle(3);
        // producer r7, consumer of r7 held four cycles
        put(1, 0, 0, 0, 0, 1, 7, 0, 0); cyc();
        put(1, 1, 7, 0, 0, 0, 0, 0, 0);
        chk("r7 c1 a.fwd_sel1", 32'(ifa.fwd_sel1), 1);
        chk("r7 c1 b.stall", 32'(ifb.stall), 1);
        chk("r7 c1 b.fwd_sel1", 32'(ifb.fwd_sel1), 0);
        cyc(); #1;
        chk("r7 c2 a.fwd_sel1", 32'(ifa.fwd_sel1), 2);
        chk("r7 c2 b.stall", 32'(ifb.stall), 1);
        cyc(); #1;
        chk("r7 c3 a.fwd_sel1", 32'(ifa.fwd_sel1), 3);
        chk("r7 c3 b.stall", 32'(ifb.stall), 1);
        cyc(); #1;
        chk("r7 c4 a.fwd_sel1", 32'(ifa.fwd_sel1), 0);
        chk("r7 c4 b.stall", 32'(ifb.stall), 0);
        chk("r7 c4 b.stall_cnt", 32'(ifb.stall_cnt), 7);
        cyc(); idle(3);
        // write r0 then read r0 on both operands
        put(1, 0, 0, 0, 0, 1, 0, 0, 0); cyc();
        put(1, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("r0 a.stall", 32'(ifa.stall), 0);
        chk("r0 a.fwd_sel1", 32'(ifa.fwd_sel1), 0);
        chk("r0 a.fwd_sel2", 32'(ifa.fwd_sel2), 0);
        chk("r0 a.busy_map0", 32'(ifa.busy_map[0]), 1);
        chk("r0 b.stall", 32'(ifb.stall), 0);
        cyc(); idle(3);
        // flush during a load-use stall
        put(1, 0, 0, 0, 0, 1, 5, 1, 0); cyc();
        put(1, 1, 5, 0, 0, 1, 6, 0, 0);
        chk("flush c1 a.stall", 32'(ifa.stall), 1);
        chk("flush c1 b.stall", 32'(ifb.stall), 1);
        cyc();
        put(1, 1, 5, 0, 0, 1, 6, 0, 1);
        chk("flush a.stall", 32'(ifa.stall), 0);
        chk("flush b.stall", 32'(ifb.stall), 0);
        chk("flush a.stall_cnt", 32'(ifa.stall_cnt), 3);
        chk("sat b.stall_cnt", 32'(ifb.stall_cnt), 7);
        cyc(); put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush a.busy_map", 32'(ifa.busy_map), 4);
        idle(3);
        // both operands: lw r8, add r9, consumer r9/r8
        put(1, 0, 0, 0, 0, 1, 8, 1, 0); cyc();
        put(1, 0, 0, 0, 0, 1, 9, 0, 0); cyc();
        put(1, 1, 9, 1, 8, 0, 0, 0, 0);
        chk("both c1 a.fwd_sel1", 32'(ifa.fwd_sel1), 1);
        chk("both c1 a.fwd_sel2", 32'(ifa.fwd_sel2), 2);
        chk("both c1 a.stall", 32'(ifa.stall), 1);
        cyc(); #1;
        chk("both c2 a.fwd_sel1", 32'(ifa.fwd_sel1), 2);
        chk("both c2 a.fwd_sel2", 32'(ifa.fwd_sel2), 3);
        chk("both c2 a.stall", 32'(ifa.stall), 0);
        chk("both c2 a.stall_cnt", 32'(ifa.stall_cnt), 4);
        cyc(); idle(3);
        // two writers of r10, youngest wins; ren1 low masks operand 1
        put(1, 0, 0, 0, 0, 1, 10, 0, 0); cyc();
        put(1, 0, 0, 0, 0, 1, 10, 0, 0); cyc();
        put(1, 0, 10, 1, 10, 0, 0, 0, 0);
        chk("young a.fwd_sel1", 32'(ifa.fwd_sel1), 0);
        chk("young a.fwd_sel2", 32'(ifa.fwd_sel2), 1);
        cyc(); idle(3);
        // fill pipeline, then reset asynchronously mid-cycle
        put(1, 0, 0, 0, 0, 1, 12, 1, 0); cyc();
        put(1, 0, 0, 0, 0, 1, 13, 0, 0); cyc();
        put(1, 1, 12, 0, 0, 1, 14, 0, 0);
        chk("fill a.stall", 32'(ifa.stall), 1);
        cyc(); #1;
        chk("fill a.fwd_sel1", 32'(ifa.fwd_sel1), 3);
        cyc();
        put(1, 0, 0, 0, 0, 1, 15, 0, 0); cyc();
        put(1, 0, 0, 0, 0, 1, 16, 0, 0); cyc();
        put(1, 1, 16, 0, 0, 0, 0, 0, 0);
        chk("pre-rst a.busy_map", 32'(ifa.busy_map), 7);
        chk("pre-rst a.stall_cnt", 32'(ifa.stall_cnt), 5);
        chk("pre-rst a.fwd_sel1", 32'(ifa.fwd_sel1), 1);
        chk("pre-rst b.stall", 32'(ifb.stall), 1);
        rst = 1'b1;
        #1;
        chk("async a.busy_map", 32'(ifa.busy_map), 0);
        chk("async a.stall_cnt", 32'(ifa.stall_cnt), 0);
        chk("async a.stall", 32'(ifa.stall), 0);
        chk("async a.fwd_sel1", 32'(ifa.fwd_sel1), 0);
        chk("async b.stall", 32'(ifb.stall), 0);
        cyc();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(); cyc();
        chk("post-rst a.busy_map", 32'(ifa.busy_map), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
